// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: 7-bit addressed I2C slave bridging the bus to a byte-wide register port.
// SCL/SDA are synchronised to clk and all bit handling is qualified on synchronised SCL edges.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    state_t           st, st_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             rw, rw_nxt;
    logic             sda_oe_nxt, wr_valid_nxt, busy_nxt;
    logic [PTR_W-1:0] wr_addr_nxt;
    logic [7:0]       wr_data_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    // p0/p1: two-flop synchronisers (idle bus level after reset); p2: previous sample for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {scl_p0, scl_p1, scl_p2} <= 3'b111;
            {sda_p0, sda_p1, sda_p2} <= 3'b111;
        end else begin
            {scl_p0, scl_p1, scl_p2} <= {scl_in, scl_p0, scl_p1};
            {sda_p0, sda_p1, sda_p2} <= {sda_in, sda_p0, sda_p1};
        end
    end

    // START/STOP need SCL stable high, so a coincident SCL edge suppresses them
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
    assign byte_in   = {shreg[6:0], sda_p1};

    always_comb begin
        st_nxt       = st;
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        rw_nxt       = rw;
        sda_oe_nxt   = sda_oe;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        if (stop_det) begin
            st_nxt     = IDLE;
            sda_oe_nxt = 1'b0;
        end else if (start_det) begin
            st_nxt     = ADDR;
            cnt_nxt    = 4'd0;
            sda_oe_nxt = 1'b0;
        end else begin
            case (st)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt = byte_in;
                        cnt_nxt   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_nxt = 4'd0;
                            if (st == ADDR) begin
                                rw_nxt = byte_in[0];
                                st_nxt = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                            end else if (st == PTR) begin
                                if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                                    ptr_nxt = PTR_W'(byte_in);
                                    st_nxt  = PTR_ACK;
                                end else begin
                                    st_nxt  = IDLE;
                                end
                            end else begin
                                wr_valid_nxt = 1'b1;
                                wr_addr_nxt  = ptr;
                                wr_data_nxt  = byte_in;
                                ptr_nxt      = ptr_inc(ptr);
                                st_nxt       = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // cnt 0: next fall starts the ACK bit; cnt 1: next fall ends it
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            cnt_nxt    = 4'd1;
                            sda_oe_nxt = 1'b1;
                        end else begin
                            cnt_nxt    = 4'd0;
                            sda_oe_nxt = 1'b0;
                            if (st == ADDR_ACK && rw) begin
                                shreg_nxt  = rd_data;
                                sda_oe_nxt = ~rd_data[7];
                                ptr_nxt    = ptr_inc(ptr);
                                st_nxt     = RDATA;
                            end else begin
                                st_nxt = (st == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_nxt = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            cnt_nxt    = 4'd0;
                            sda_oe_nxt = 1'b0;
                            st_nxt     = RDATA_ACK;
                        end else begin
                            shreg_nxt  = {shreg[6:0], shreg[7]};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_p1) st_nxt = IDLE;
                        else        cnt_nxt = 4'd1;
                    end else if (scl_fall && cnt == 4'd1) begin
                        shreg_nxt  = rd_data;
                        sda_oe_nxt = ~rd_data[7];
                        ptr_nxt    = ptr_inc(ptr);
                        cnt_nxt    = 4'd0;
                        st_nxt     = RDATA;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
        busy_nxt = (st_nxt != IDLE);
    end

    // control and port registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= 4'd0;
            ptr      <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            sda_oe   <= sda_oe_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    assign rd_addr = ptr;
    assign state   = st;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: directed I2C master transactions against i2c_slave_regs with hand-computed results.
// rd_data is modelled as rd_addr*0x11; SDA is an open-drain wired-AND of master and slave.
module tb_i2c_slave_regs;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             scl_m, sda_m;
    logic             sda_oe, wr_valid, busy;
    logic [PTR_W-1:0] wr_addr, rd_addr;
    logic [7:0]       wr_data, rd_data;
    logic [3:0]       state;
    logic             sda_line;

    int n_checks = 0;
    int n_fail   = 0;

    int               wr_cnt = 0;
    int               oe_cnt = 0;
    logic [11:0]      wr_log [16];

    assign sda_line = sda_m & ~sda_oe;
    assign rd_data  = {4'd0, rd_addr} * 8'h11;

    i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Monotonic logs of write pulses and SDA-drive cycles, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_cnt < 16) wr_log[wr_cnt] <= {wr_addr, wr_data};
            wr_cnt <= wr_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        b = sda_line;
        wait_clk(5);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        int         wr_base, oe_base;

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(3);
        @(negedge clk);
        chk("rst_sda_oe",   sda_oe,   0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr",  wr_addr,  0);
        chk("rst_wr_data",  wr_data,  0);
        chk("rst_rd_addr",  rd_addr,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_state",    state,    0);
        reset = 1'b0;
        wait_clk(5);

        // Write 0xA5, 0x5A starting at register 3
        wr_base = wr_cnt;
        i2c_start();
        chk("wr_busy_after_start", busy, 1);
        send_byte(8'h84, ack); chk("wr_ack_addr", ack, 0);
        send_byte(8'h03, ack); chk("wr_ack_ptr",  ack, 0);
        send_byte(8'hA5, ack); chk("wr_ack_d0",   ack, 0);
        send_byte(8'h5A, ack); chk("wr_ack_d1",   ack, 0);
        i2c_stop();
        chk("wr_pulses",     wr_cnt - wr_base, 2);
        chk("wr_first",      wr_log[wr_base],     12'h3A5);
        chk("wr_second",     wr_log[wr_base + 1], 12'h45A);
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_state_idle", state, 0);
        chk("wr_ptr",        rd_addr, 5);
        chk("wr_addr_hold",  wr_addr, 4);
        chk("wr_data_hold",  wr_data, 8'h5A);

        // Wrong address: slave must stay silent
        wr_base = wr_cnt;
        oe_base = oe_cnt;
        i2c_start();
        send_byte(8'h86, ack); chk("wa_nack_addr", ack, 1);
        send_byte(8'h00, ack); chk("wa_nack_data", ack, 1);
        i2c_stop();
        chk("wa_oe_never", oe_cnt - oe_base, 0);
        chk("wa_no_write", wr_cnt - wr_base, 0);
        chk("wa_state",    state, 0);
        chk("wa_ptr",      rd_addr, 5);

        // Read across the pointer wrap with a repeated START
        i2c_start();
        send_byte(8'h84, ack); chk("rd_ack_addr", ack, 0);
        send_byte(8'h0F, ack); chk("rd_ack_ptr",  ack, 0);
        i2c_start();
        send_byte(8'h85, ack); chk("rd_ack_addr_r", ack, 0);
        recv_byte(b, 1'b0);    chk("rd_byte0", b, 8'hFF);
        recv_byte(b, 1'b1);    chk("rd_byte1", b, 8'h00);
        wait_clk(5);
        chk("rd_sda_released", sda_oe, 0);
        chk("rd_state_idle",   state, 0);
        i2c_stop();
        chk("rd_ptr_end", rd_addr, 1);
        chk("rd_busy",    busy, 0);

        // Out-of-range pointer is NACKed and ignored
        i2c_start();
        send_byte(8'h84, ack); chk("oor_ack_addr", ack, 0);
        send_byte(8'h20, ack); chk("oor_nack_ptr", ack, 1);
        chk("oor_state", state, 0);
        i2c_stop();
        chk("oor_ptr", rd_addr, 1);

        // STOP in the middle of a data byte discards it
        wr_base = wr_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("sm_ack_addr", ack, 0);
        send_byte(8'h01, ack); chk("sm_ack_ptr",  ack, 0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        i2c_stop();
        chk("sm_no_write", wr_cnt - wr_base, 0);
        chk("sm_state",    state, 0);
        chk("sm_ptr",      rd_addr, 1);

        // Asynchronous reset while the slave drives SDA (register 2 = 0x22, MSB 0)
        i2c_start();
        send_byte(8'h84, ack); chk("ar_ack_addr", ack, 0);
        send_byte(8'h02, ack); chk("ar_ack_ptr",  ack, 0);
        i2c_start();
        send_byte(8'h85, ack); chk("ar_ack_addr_r", ack, 0);
        @(negedge clk);
        chk("ar_sda_driven", sda_oe, 1);
        chk("ar_ptr_before", rd_addr, 3);
        #2 reset = 1'b1;
        #1;
        chk("ar_sda_async", sda_oe,   0);
        chk("ar_wr_valid",  wr_valid, 0);
        chk("ar_wr_addr",   wr_addr,  0);
        chk("ar_wr_data",   wr_data,  0);
        chk("ar_rd_addr",   rd_addr,  0);
        chk("ar_busy",      busy,     0);
        chk("ar_state",     state,    0);
        wait_clk(2);
        reset = 1'b0;
        i2c_stop();
        chk("ar_state_end", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
